// File: rtl/register_file_2w.sv
// Two-read / two-write register file with optional write-to-read bypass,
// PC-relative reads of the PC index and a registered PC redirect output.
module register_file_2w #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int PC_IDX    = 15,
  parameter int PC_OFFSET = 8,
  parameter bit BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              WE4,
  input  logic [DATA_W-1:0] R15,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              pc_wr,
  output logic [DATA_W-1:0] pc_wd,
  output logic              wr_collide
);

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] PC_ADD     = DATA_W'(PC_OFFSET);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              pc_wr_r;
  logic [DATA_W-1:0] pc_wd_r;
  logic              wr_collide_r;

  logic              acc3_s, acc4_s, same_addr_s;
  logic              arr3_s, arr4_s, pc3_s, pc4_s;
  logic [DATA_W-1:0] pc_read_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < NUM_REGS_W);
  endfunction

  // Read resolution: PC index first, then range, then bypass ports, then array.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] pc_val,
    input logic              we3,
    input logic [ADDR_W-1:0] a3,
    input logic [DATA_W-1:0] wd3,
    input logic              we4,
    input logic [ADDR_W-1:0] a4,
    input logic [DATA_W-1:0] wd4
  );
    logic [DATA_W-1:0] val;
    if (addr == PC_ADDR) begin
      val = pc_val;
    end else if (!in_range(addr)) begin
      val = {DATA_W{1'b0}};
    end else if (BYPASS && we3 && (a3 == addr)) begin
      val = wd3;
    end else if (BYPASS && we4 && (a4 == addr)) begin
      val = wd4;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write acceptance, port-3 priority on collision, PC-index steering.
  always_comb begin
    acc3_s      = WE3 && in_range(A3);
    acc4_s      = WE4 && in_range(A4);
    same_addr_s = acc3_s && acc4_s && (A3 == A4);
    pc3_s       = acc3_s && (A3 == PC_ADDR);
    pc4_s       = acc4_s && (A4 == PC_ADDR) && !same_addr_s;
    arr3_s      = acc3_s && (A3 != PC_ADDR);
    arr4_s      = acc4_s && (A4 != PC_ADDR) && !same_addr_s;
    pc_read_s   = R15 + PC_ADD;
  end

  // Combinational read ports.
  always_comb begin
    RD1 = resolve(A1, regs_r[A1], pc_read_s, WE3, A3, WD3, WE4, A4, WD4);
    RD2 = resolve(A2, regs_r[A2], pc_read_s, WE3, A3, WD3, WE4, A4, WD4);
  end

  // Register array storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (arr3_s && (A3 == ADDR_W'(i))) begin
          regs_r[i] <= WD3;
        end else if (arr4_s && (A4 == ADDR_W'(i))) begin
          regs_r[i] <= WD4;
        end
      end
    end
  end

  // PC redirect and collision status; pc_wd holds between redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_wr_r      <= 1'b0;
      pc_wd_r      <= {DATA_W{1'b0}};
      wr_collide_r <= 1'b0;
    end else begin
      pc_wr_r      <= pc3_s || pc4_s;
      wr_collide_r <= same_addr_s;
      if (pc3_s) begin
        pc_wd_r <= WD3;
      end else if (pc4_s) begin
        pc_wd_r <= WD4;
      end
    end
  end

  assign pc_wr      = pc_wr_r;
  assign pc_wd      = pc_wd_r;
  assign wr_collide = wr_collide_r;

endmodule

// File: doc/register_file_2w.md
Name: register_file_2w

Overview:
- Parametrised successor to the current single-write register file. It provides two read ports and two write ports, optional same-cycle write-to-read bypass, and PC-relative reads of the PC index.
- Sits in the datapath between decode (read addresses), writeback (WD3, ALU result) and load/base-update writeback (WD4). The PC value enters on R15.
- Writes to the PC index are not stored in the array. They are reported on a registered redirect output that feeds the fetch stage.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- NUM_REGS, 16, number of architectural registers, including the PC index.
- ADDR_W, 4, address width. Must satisfy 2**ADDR_W >= NUM_REGS.
- PC_IDX, 15, register index that maps to the PC.
- PC_OFFSET, 8, constant added to R15 when PC_IDX is read.
- BYPASS, 1. 1 = a read returns the data being written to that address in the same cycle. 0 = a read returns the stored value.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- A1, input, ADDR_W, read port 1 address.
- A2, input, ADDR_W, read port 2 address.
- A3, input, ADDR_W, write port 3 address.
- WD3, input, DATA_W, write port 3 data.
- WE3, input, 1, write port 3 enable.
- A4, input, ADDR_W, write port 4 address.
- WD4, input, DATA_W, write port 4 data.
- WE4, input, 1, write port 4 enable.
- R15, input, DATA_W, current PC value.
- RD1, output, DATA_W, read port 1 data (combinational).
- RD2, output, DATA_W, read port 2 data (combinational).
- pc_wr, output, 1, registered one-cycle pulse: a write to PC_IDX was accepted.
- pc_wd, output, DATA_W, registered PC write data. Valid while pc_wr=1 and held otherwise.
- wr_collide, output, 1, registered one-cycle pulse: both write ports targeted the same address in the previous cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - All array entries clear to 0.
  - pc_wr, pc_wd and wr_collide clear to 0.
  - Release from reset is synchronous to clk.
  - RD1/RD2 still follow their read rules during reset: array reads return 0 and PC_IDX reads return R15+PC_OFFSET.
- Write acceptance, at the rising clk edge when rst=1:
  - Port 3 is accepted if WE3=1 and A3<NUM_REGS.
  - Port 4 is accepted under the same rule with WE4/A4.
  - An address >= NUM_REGS is silently dropped.
- Same-address collision, A3==A4 with both ports accepted:
  - Port 3 wins. WD4 is discarded.
  - wr_collide=1 on the next cycle, otherwise 0.
- Writes to PC_IDX:
  - Never update the array.
  - On the next cycle: pc_wr=1, and pc_wd takes the winning port's data, with the same port-3 priority rule.
  - pc_wr=0 on any cycle without a PC write.
- Latency:
  - A write is visible on RD1/RD2 the cycle after the edge when BYPASS=0.
  - It is visible in the same cycle when BYPASS=1.
- Read resolution, per port, in priority order:
  1. Address == PC_IDX: return R15 + PC_OFFSET, truncated modulo 2**DATA_W. Never bypassed.
  2. Address >= NUM_REGS: return 0.
  3. BYPASS=1 and WE3=1 and A3==address: return WD3.
  4. BYPASS=1 and WE4=1 and A4==address: return WD4.
  5. Otherwise: return the stored array entry.
- Arithmetic:
  - The PC add is unsigned with wrap, e.g. R15=FFFFFFFC gives FFFFFFFC+8 = 00000004.
  - There is no carry out.
- Simultaneous read/write with BYPASS=0: the read returns the old value in the write cycle and the new value after the edge.
- Reset asserted mid-write: the reset wins and the write is lost. pc_wr and wr_collide are forced to 0 immediately.
- There is no hardwired zero register. All indices other than PC_IDX are general purpose.

Test Plan:
- Reset clears the array:
  - Stimulus: write R3=DEADBEEF, then pulse rst=0 asynchronously between clock edges.
  - Response: RD1 (A1=3) drops to 00000000 immediately. pc_wr=0 and wr_collide=0.
- Dual write to different addresses:
  - Stimulus: WE3=1 A3=1 WD3=12345678 and WE4=1 A4=2 WD4=87654321 in one cycle.
  - Response: next cycle RD1 (A1=1)=12345678 and RD2 (A2=2)=87654321. wr_collide=0.
- Collision:
  - Stimulus: WE3=1 WE4=1 A3=A4=5, WD3=AAAA0000, WD4=5555FFFF.
  - Response: R5 reads AAAA0000. wr_collide=1 for exactly one cycle.
- Bypass:
  - Stimulus, BYPASS=1: WE3=1 A3=7 WD3=CAFEF00D with A1=7 in the same cycle.
  - Response: RD1=CAFEF00D before the edge.
  - Stimulus, BYPASS=0: the same write.
  - Response: RD1 shows the old value 00000000 until the edge, then CAFEF00D.
- PC read:
  - Stimulus: R15=00000010, A1=15.
  - Response: RD1=00000018.
  - Stimulus: R15=FFFFFFFC.
  - Response: RD1=00000004.
- PC write:
  - Stimulus: WE4=1 A4=15 WD4=00001000.
  - Response: next cycle pc_wr=1 and pc_wd=00001000. The following cycle pc_wr=0. RD1 (A1=15) still returns R15+8.
  - Stimulus: WE3=1 A3=14 WD3=1, with WE=0 on a later cycle.
  - Response: R14 retains 1.
